// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that feeds a UART transmitter through a
// ready / active / done handshake. The transmitter status inputs are
// asynchronous and are brought into clk through two-flop synchronizers.
//
// Optional feature: define UART_TX_FIFO_OVF_EN to add the sticky
// o_overflow flag. It is set by any write dropped while full.
//
// DEPTH must be a power of two and at least 2. With a power of two, the
// pointers wrap from DEPTH-1 to 0 on plain binary overflow.
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | no request outstanding; pop as soon as FIFO non-empty
// REQ       | o_tx_ready high, o_tx_data held until act_s seen
// WAIT_DONE | transmitter busy; wait for a rising edge of done_s
module uart_tx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    i_wr_data,
    input  logic          i_wr_en,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_level,
    output logic [7:0]    o_tx_data,
    output logic          o_tx_ready,
    input  logic          i_tx_active,
    input  logic          i_tx_done
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic          o_overflow
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE} state_t;

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          act_q, act_s;
    logic          done_q, done_s, done_d;
    logic          push;
    logic          pop;
    logic          done_evt;
    logic [AW:0]   level_nxt;

    // A write is taken only when not full, regardless of a same-cycle pop.
    assign push     = i_wr_en && !o_full;
    assign pop      = (state == IDLE) && !o_empty;
    assign done_evt = done_s && !done_d;

    // Synchronize transmitter status; done_d is the edge-detect copy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            act_q  <= 1'b0;
            act_s  <= 1'b0;
            done_q <= 1'b0;
            done_s <= 1'b0;
            done_d <= 1'b0;
        end else begin
            act_q  <= i_tx_active;
            act_s  <= act_q;
            done_q <= i_tx_done;
            done_s <= done_q;
            done_d <= done_s;
        end
    end

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        level_nxt = o_level;
        if (push && !pop) begin
            level_nxt = o_level + LVL_ONE;
        end else if (pop && !push) begin
            level_nxt = o_level - LVL_ONE;
        end
    end

    // Storage write; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= i_wr_data;
        end
    end

    // Write pointer, level and the registered full/empty flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr    <= '0;
            o_level <= '0;
            o_empty <= 1'b1;
            o_full  <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            o_level <= level_nxt;
            o_empty <= (level_nxt == '0);
            o_full  <= (level_nxt == LVL_FULL);
        end
    end

    // Handshake FSM; a pop happens only when leaving IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            rptr       <= '0;
            o_tx_ready <= 1'b0;
            o_tx_data  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (!o_empty) begin
                        o_tx_data  <= mem[rptr];
                        rptr       <= rptr + AW'(1);
                        o_tx_ready <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (act_s) begin
                        o_tx_ready <= 1'b0;
                        state      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (done_evt) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    o_tx_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    // Sticky record of any write dropped because the FIFO was full.
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_overflow <= 1'b0;
        end else if (i_wr_en && o_full) begin
            o_overflow <= 1'b1;
        end
    end
`endif

endmodule
